// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: branch/jump opcodes, fetch queue entry, word size.
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam int unsigned XLEN    = 32;
  localparam logic [31:0] sz_word = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue with synchronous clear; an entry is readable the cycle after its push.
// No internal backpressure: a push while full is dropped unless a pop happens in the same cycle.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = fetch_entry_t,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  T              push_dat_i,
  input  logic          pop_i,
  output T              head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_comb begin
    do_push = push_i && (!full_o || pop_i);
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: pipelined imem requests, DEPTH-entry return queue, valid/ready to decode; gnt->id_valid = mem latency + 1.
// Requests stall once queued + in-flight reach DEPTH; FETCH_PREDICT_EN adds static j/jal and backward-branch prediction.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_pred_taken
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [ADDR_W-1:0] pc_shadow_q [DEPTH];
  logic [AW-1:0]     sh_wptr_q, sh_rptr_q;
  logic [CW-1:0]     occ;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      push_entry, head_entry;
  logic              issue, resp, push, pop, resp_pred;
  logic [ADDR_W-1:0] resp_pc;
  logic              unused_ok;

  assign unused_ok = ^{redirect_pc[1:0], fifo_full};

  // Credits: every request in flight already owns a queue slot, so a push never finds the queue full.
  assign imem_req  = !reset && !redirect_valid && (({1'b0, occ} + {1'b0, outst_q}) < DEPTH_C);
  assign imem_addr = {fetch_pc_q[ADDR_W-1:2], 2'b00};
  assign issue     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outst_q != '0);
  assign push      = resp && (disc_q == '0) && !redirect_valid;
  assign pop       = id_valid && id_ready;
  assign resp_pc   = pc_shadow_q[sh_rptr_q];

`ifdef FETCH_PREDICT_EN
  logic [5:0]        opcode;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pred_target;

  always_comb begin
    opcode      = imem_rdata[31:26];
    imm         = imem_rdata[15:0];
    resp_pred   = 1'b0;
    pred_target = resp_pc + ADDR_W'(sz_word);
    if (opcode == OP_J || opcode == OP_JAL) begin
      resp_pred   = 1'b1;
      pred_target = {resp_pc[ADDR_W-1:28], imem_rdata[25:0], 2'b00};
    end else if ((opcode == OP_BEQ || opcode == OP_BNE) && imm[15]) begin
      resp_pred   = 1'b1;
      pred_target = resp_pc + ADDR_W'(sz_word) + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    end
  end
`else
  assign resp_pred = 1'b0;
`endif

  always_comb begin
    outst_d = outst_q;
    if (issue && !resp)      outst_d = outst_q + CW'(1);
    else if (!issue && resp) outst_d = outst_q - CW'(1);
    disc_d = disc_q;
    if (resp && disc_q != '0) disc_d = disc_q - CW'(1);
    fetch_pc_d = fetch_pc_q;
    if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(sz_word);
`ifdef FETCH_PREDICT_EN
    if (push && resp_pred) begin
      disc_d     = outst_d;
      fetch_pc_d = pred_target;
    end
`endif
    // Whatever is still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      disc_d     = outst_d;
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.instr      = imem_rdata;
    push_entry.pc         = resp_pc;
    push_entry.pred_taken = resp_pred;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= PC_INIT;
      outst_q    <= '0;
      disc_q     <= '0;
      sh_wptr_q  <= '0;
      sh_rptr_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      if (issue) sh_wptr_q <= sh_wptr_q + AW'(1);
      if (resp)  sh_rptr_q <= sh_rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_shadow_q[sh_wptr_q] <= imem_addr;
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .T    (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (redirect_valid),
    .push_i    (push),
    .push_dat_i(push_entry),
    .pop_i     (pop),
    .head_o    (head_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (occ)
  );

  assign id_valid      = !fifo_empty && !redirect_valid;
  assign id_instr      = id_valid ? head_entry.instr : '0;
  assign id_pc         = id_valid ? head_entry.pc : '0;
  assign id_pred_taken = id_valid && head_entry.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model, expected instruction stream derived from PC rules.
module tb_fetch_unit;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_pred_taken;

  fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .PC_INIT(PC_INIT)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pred_taken(id_pred_taken)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Instruction memory contents: lw-style filler everywhere, a backward bne at 0x10.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h10) return 32'h1400_FFFC;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return {6'b100011, h[25:0]};
  endfunction

  // Architectural next-PC rule the delivered stream must follow.
  function automatic void next_of(input logic [31:0] pc, input logic [31:0] ins,
                                  output logic taken, output logic [31:0] nxt);
    taken = 1'b0;
    nxt   = pc + 32'd4;
`ifdef FETCH_PREDICT_EN
    if (ins[31:26] == 6'b000010 || ins[31:26] == 6'b000011) begin
      taken = 1'b1;
      nxt   = {pc[31:28], ins[25:0], 2'b00};
    end else if ((ins[31:26] == 6'b000100 || ins[31:26] == 6'b000101) && ins[15]) begin
      taken = 1'b1;
      nxt   = pc + 32'd4 + ({{16{ins[15]}}, ins[15:0]} << 2);
    end
`endif
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gen_pc;

  function automatic void top_up();
    exp_t e;
    logic [31:0] nxt;
    while (exp_q.size() < 16) begin
      e.pc    = gen_pc;
      e.instr = memfn(gen_pc);
      next_of(e.pc, e.instr, e.pt, nxt);
      exp_q.push_back(e);
      gen_pc = nxt;
    end
  endfunction

  function automatic void restart(input logic [31:0] tgt);
    exp_q.delete();
    gen_pc = {tgt[31:2], 2'b00};
    top_up();
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int unsigned gnt_pct = 100, rdy_pct = 100, lat = 1, redir_pm = 0;
  logic        rst_drv = 1'b1;
  logic        force_redir = 1'b0;
  logic [31:0] force_tgt = '0;
  int          cyc = 0, grant_cnt = 0, delivered = 0;
  logic [31:0] last_pc = '0;
  logic        redir_prev = 1'b0;
  exp_t        mon_e;

  // One clock cycle: drive inputs after the edge, record grants at the falling edge.
  task automatic step();
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst_drv;
    if (rst_drv) mq.delete();
    if (!rst_drv && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
    imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    id_ready = ($urandom_range(0, 99) < rdy_pct);
    if (!rst_drv && (force_redir || $urandom_range(0, 999) < redir_pm)) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_redir ? force_tgt : (($urandom_range(0, 255) << 2) | $urandom_range(0, 3));
      restart(redirect_pc);
    end else begin
      redirect_valid = 1'b0;
    end
    top_up();
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + int'(lat);
      mq.push_back(r);
      grant_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_drv     = 1'b1;
    force_redir = 1'b0;
    redir_pm    = 0;
    repeat (3) step();
    rst_drv = 1'b0;
    restart(PC_INIT);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (redirect_valid || redir_prev) chk("id_valid_low_around_redirect", 32'(id_valid), 32'd0);
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow actual_pc=0x%08h required=no_delivery", id_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("id_pc", id_pc, mon_e.pc);
          chk("id_instr", id_instr, mon_e.instr);
          chk("id_pred_taken", 32'(id_pred_taken), 32'(mon_e.pt));
        end
        delivered++;
        last_pc = id_pc;
      end
    end
    redir_prev = redirect_valid && !reset;
  end

  initial begin
    int d0, g0;
    logic [31:0] a0;

    gnt_pct = 100; rdy_pct = 100; lat = 1;
    rst_drv = 1'b1;
    repeat (3) step();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, PC_INIT);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pred_taken", 32'(id_pred_taken), 32'd0);

    // Reset release, single-cycle memory, decode always ready.
    rst_drv = 1'b0;
    restart(PC_INIT);
    step();
    chk("t1_req_c0", 32'(imem_req), 32'd1);
    chk("t1_addr_c0", imem_addr, PC_INIT);
    chk("t1_valid_c0", 32'(id_valid), 32'd0);
    step();
    chk("t1_addr_c1", imem_addr, PC_INIT + 32'd4);
    chk("t1_valid_c1", 32'(id_valid), 32'd0);
    step();
    chk("t1_addr_c2", imem_addr, PC_INIT + 32'd8);
    chk("t1_valid_c2", 32'(id_valid), 32'd1);
    chk("t1_pc_c2", id_pc, PC_INIT);
    d0 = delivered;
    repeat (3) step();
    chk("t1_throughput", 32'(delivered - d0), 32'd3);

    // Decode stalled: credits must stop requests at DEPTH.
    do_reset();
    rdy_pct = 0;
    g0 = grant_cnt;
    repeat (10) step();
    chk("t2_grants", 32'(grant_cnt - g0), DEPTH);
    chk("t2_req_low", 32'(imem_req), 32'd0);
    chk("t2_valid_full", 32'(id_valid), 32'd1);
    rdy_pct = 100;
    d0 = delivered;
    repeat (12) step();
    chk("t2_drained", 32'(delivered - d0 >= int'(DEPTH)), 32'd1);

    // Grant withheld for 3 cycles: address must hold.
    do_reset();
    repeat (4) step();
    gnt_pct = 0;
    step();
    a0 = imem_addr;
    repeat (3) begin
      step();
      chk("t3_addr_stable", imem_addr, a0);
      chk("t3_req_held", 32'(imem_req), 32'd1);
    end
    gnt_pct = 100;
    step();
    chk("t3_addr_granted", imem_addr, a0);
    step();
    chk("t3_no_skip", imem_addr, a0 + 32'd4);
    repeat (10) step();

    // Three-cycle memory, redirect with two requests in flight.
    do_reset();
    lat = 3;
    step();
    step();
    chk("t4_in_flight", 32'(mq.size()), 32'd2);
    force_redir = 1'b1;
    force_tgt   = 32'h40;
    step();
    force_redir = 1'b0;
    chk("t4_req_in_redirect", 32'(imem_req), 32'd0);
    step();
    chk("t4_new_addr", imem_addr, 32'h40);
    chk("t4_new_req", 32'(imem_req), 32'd1);
    d0 = delivered;
    for (int i = 0; i < 20 && delivered == d0; i++) step();
    chk("t4_delivery_seen", 32'(delivered != d0), 32'd1);
    chk("t4_first_pc", last_pc, 32'h40);
    repeat (10) step();

    // Full queue, decode turns ready in the redirect cycle.
    do_reset();
    lat = 1;
    rdy_pct = 0;
    repeat (8) step();
    chk("t5_full_valid", 32'(id_valid), 32'd1);
    chk("t5_full_req", 32'(imem_req), 32'd0);
    rdy_pct = 100;
    force_redir = 1'b1;
    force_tgt   = 32'h100;
    step();
    force_redir = 1'b0;
    chk("t5_valid_redirect_cycle", 32'(id_valid), 32'd0);
    step();
    chk("t5_valid_next_cycle", 32'(id_valid), 32'd0);
    chk("t5_new_addr", imem_addr, 32'h100);
    repeat (10) step();

    // Random traffic with redirects, latency changes and a mid-run reset.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      if (p == 2) do_reset();
      gnt_pct  = 70;
      rdy_pct  = 70;
      redir_pm = 25;
      lat      = 1 + (p % 3);
      repeat (600) step();
    end

    redir_pm = 0;
    gnt_pct  = 100;
    rdy_pct  = 100;
    d0 = delivered;
    repeat (30) step();
    chk("final_progress", 32'(delivered - d0 >= 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
